plot_arbiter: RTL and testbench

Shares the single VGA-adapter pixel-write port (x, y, colour, plot) between several pixel producers: background eraser, square drawer and catcher drawer. Each producer requests a burst, is granted the port round-robin, streams pixels with a per-pixel valid/ack handshake, and releases the port with a last-pixel flag. Sits between the drawing datapaths and the VGA adapter, letting the game controller start several drawers at once instead of strictly serialising them.

---
 rtl/plot_arb_pkg.sv | 10 +
 rtl/plot_arbiter_rr_pick.sv | 27 ++
 rtl/plot_arbiter.sv | 90 +++++++++
 tb/tb_plot_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/plot_arb_pkg.sv
// plot_arb_pkg: shared types, default widths and requester indices for the pixel-port arbiter.
package plot_arb_pkg;
   typedef enum logic {IDLE, GRANT} arb_state_e;
   localparam int DEF_X_W = 8;
   localparam int DEF_Y_W = 7;
   localparam int DEF_C_W = 3;
   localparam int REQ_ERASE = 0;
   localparam int REQ_SQUARES = 1;
   localparam int REQ_CATCHER = 2;
endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request scanning upward from ptr with wrap.
module rr_pick #(
   parameter int N = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  oh,
   output logic [PW-1:0] idx,
   output logic          any
);
   always_comb begin
      oh = '0;
      idx = '0;
      any = |req;
      // scan farthest offset first so the nearest request to ptr wins
      for (int k = N - 1; k >= 0; k--) begin
         int j;
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            oh = '0;
            oh[j] = 1'b1;
            idx = PW'(j);
         end
      end
   end
endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin owner of the VGA pixel-write port; bursts end on last or on stall timeout.
module plot_arbiter
   import plot_arb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W,
   parameter int C_W = DEF_C_W,
   parameter int TIMEOUT = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   last,
   input  logic [N_REQ*X_W-1:0] x_in,
   input  logic [N_REQ*Y_W-1:0] y_in,
   input  logic [N_REQ*C_W-1:0] colour_in,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   ack,
   output logic [X_W-1:0]     out_x,
   output logic [Y_W-1:0]     out_y,
   output logic [C_W-1:0]     out_colour,
   output logic               out_plot,
   output logic               busy,
   output logic               timeout_err
);
   localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_e state, state_d;
   logic [PW-1:0] ptr, owner, pick_idx, next_ptr;
   logic [N_REQ-1:0] pick_oh;
   logic [CW-1:0] stall;
   logic any_req, accept, done, expire;

   rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
      .req(req),
      .ptr(ptr),
      .oh(pick_oh),
      .idx(pick_idx),
      .any(any_req)
   );

   assign ack = req & gnt;
   assign busy = state == GRANT;

   always_comb begin
      accept = |ack;
      done = |(ack & last);
      expire = state == GRANT && !accept && stall == CW'(TIMEOUT - 1);
      next_ptr = owner == PW'(N_REQ - 1) ? '0 : owner + 1'b1;
      state_d = state == IDLE ? (any_req ? GRANT : IDLE) : (done || expire ? IDLE : GRANT);
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gnt <= '0;
         owner <= '0;
         ptr <= PW'(REQ_ERASE);
         stall <= '0;
         out_x <= '0;
         out_y <= '0;
         out_colour <= '0;
         out_plot <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         out_plot <= accept;
         if (accept) begin
            out_x <= x_in[owner*X_W +: X_W];
            out_y <= y_in[owner*Y_W +: Y_W];
            out_colour <= colour_in[owner*C_W +: C_W];
            stall <= '0;
         end else if (state == GRANT) stall <= stall + 1'b1;
         if (state == IDLE && any_req) begin
            gnt <= pick_oh;
            owner <= pick_idx;
            stall <= '0;
         end
         if (done || expire) begin
            gnt <= '0;
            ptr <= next_ptr;
         end
         if (expire) timeout_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed vectors with hand-computed expectations for plot_arbiter.
module tb_plot_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [2:0] req = '0, last = '0;
   logic [7:0] xv [3];
   logic [6:0] yv [3];
   logic [2:0] cv [3];
   logic [23:0] x_in;
   logic [20:0] y_in;
   logic [8:0] colour_in;
   logic [2:0] gnt, ack, out_colour;
   logic [7:0] out_x;
   logic [6:0] out_y;
   logic out_plot, busy, timeout_err;
   int checks = 0, errors = 0;

   assign x_in = {xv[2], xv[1], xv[0]};
   assign y_in = {yv[2], yv[1], yv[0]};
   assign colour_in = {cv[2], cv[1], cv[0]};

   plot_arbiter dut (
      .clock(clock), .reset(reset), .req(req), .last(last),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .gnt(gnt), .ack(ack), .out_x(out_x), .out_y(out_y),
      .out_colour(out_colour), .out_plot(out_plot), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_port(input string tag, input logic [2:0] g, input logic [2:0] a, input logic p);
      chk({tag, ".gnt"}, 32'(gnt), 32'(g));
      chk({tag, ".ack"}, 32'(ack), 32'(a));
      chk({tag, ".plot"}, 32'(out_plot), 32'(p));
   endtask

   task automatic chk_zero(input string tag);
      chk_port(tag, 3'b000, 3'b000, 1'b0);
      chk({tag, ".x"}, 32'(out_x), 0);
      chk({tag, ".y"}, 32'(out_y), 0);
      chk({tag, ".c"}, 32'(out_colour), 0);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".terr"}, 32'(timeout_err), 0);
   endtask

   task automatic reset_pulse();
      @(negedge clock);
      reset = 1'b0;
      req = '0;
      last = '0;
      #1 chk_zero("rst");
      @(negedge clock);
      reset = 1'b1;
   endtask

   // req, last, expected gnt, expected ack, expected out_plot
   logic [12:0] tbl [15] = '{
      {3'b111, 3'b000, 3'b000, 3'b000, 1'b0},
      {3'b111, 3'b000, 3'b001, 3'b001, 1'b0},
      {3'b111, 3'b001, 3'b001, 3'b001, 1'b1},
      {3'b111, 3'b000, 3'b000, 3'b000, 1'b1},
      {3'b111, 3'b000, 3'b010, 3'b010, 1'b0},
      {3'b111, 3'b010, 3'b010, 3'b010, 1'b1},
      {3'b111, 3'b000, 3'b000, 3'b000, 1'b1},
      {3'b111, 3'b000, 3'b100, 3'b100, 1'b0},
      {3'b111, 3'b100, 3'b100, 3'b100, 1'b1},
      {3'b101, 3'b101, 3'b000, 3'b000, 1'b1},
      {3'b101, 3'b101, 3'b001, 3'b001, 1'b0},
      {3'b101, 3'b101, 3'b000, 3'b000, 1'b1},
      {3'b101, 3'b101, 3'b100, 3'b100, 1'b0},
      {3'b000, 3'b000, 3'b000, 3'b000, 1'b1},
      {3'b000, 3'b000, 3'b000, 3'b000, 1'b0}
   };

   initial begin
      for (int i = 0; i < 3; i++) begin
         xv[i] = '0;
         yv[i] = '0;
         cv[i] = '0;
      end
      #1 chk_zero("init");
      @(negedge clock);
      reset = 1'b1;

      // single requester, 4-pixel burst
      @(negedge clock);
      req = 3'b010;
      xv[1] = 8'd10;
      yv[1] = 7'd5;
      cv[1] = 3'b100;
      #1 chk_port("s1.req", 3'b000, 3'b000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         xv[1] = 8'(10 + i);
         last = i == 3 ? 3'b010 : 3'b000;
         #1 chk_port($sformatf("s1.px%0d", i), 3'b010, 3'b010, i > 0);
         if (i > 0) chk($sformatf("s1.x%0d", i), 32'(out_x), 32'(10 + i - 1));
      end
      @(negedge clock);
      req = '0;
      last = '0;
      #1 chk_port("s1.end", 3'b000, 3'b000, 1'b1);
      chk("s1.x", 32'(out_x), 13);
      chk("s1.y", 32'(out_y), 5);
      chk("s1.c", 32'(out_colour), 4);
      @(negedge clock);
      #1 chk_port("s1.idle", 3'b000, 3'b000, 1'b0);

      // contention from reset, then rotation with req=101
      reset_pulse();
      for (int i = 0; i < 3; i++) xv[i] = 8'(20 + i);
      for (int t = 0; t < 15; t++) begin
         @(negedge clock);
         {req, last} = tbl[t][12:7];
         #1 chk_port($sformatf("ct%0d", t), tbl[t][6:4], tbl[t][3:1], tbl[t][0]);
         if (t == 3) chk("ct.x0", 32'(out_x), 20);
         if (t == 6) chk("ct.x1", 32'(out_x), 21);
         if (t == 9) chk("ct.x2", 32'(out_x), 22);
         if (t == 11) chk("rot.x0", 32'(out_x), 20);
         if (t == 13) chk("rot.x2", 32'(out_x), 22);
      end

      // stall of 15 cycles revokes owner 1
      @(negedge clock);
      req = 3'b010;
      xv[1] = 8'd77;
      #1 chk_port("to.req", 3'b000, 3'b000, 1'b0);
      @(negedge clock);
      #1 chk_port("to.px", 3'b010, 3'b010, 1'b0);
      for (int k = 0; k < 15; k++) begin
         @(negedge clock);
         req = '0;
         #1 chk_port($sformatf("to.st%0d", k), 3'b010, 3'b000, k == 0);
         chk($sformatf("to.err%0d", k), 32'(timeout_err), 0);
      end
      @(negedge clock);
      #1 chk_port("to.drop", 3'b000, 3'b000, 1'b0);
      chk("to.err", 32'(timeout_err), 1);
      chk("to.busy", 32'(busy), 0);
      chk("to.x", 32'(out_x), 77);
      @(negedge clock);
      @(negedge clock);
      #1 chk("to.sticky", 32'(timeout_err), 1);

      // 14-cycle stall then resume: no timeout
      reset_pulse();
      @(negedge clock);
      req = 3'b010;
      #1 chk_port("ns.req", 3'b000, 3'b000, 1'b0);
      @(negedge clock);
      #1 chk_port("ns.px", 3'b010, 3'b010, 1'b0);
      for (int k = 0; k < 14; k++) begin
         @(negedge clock);
         req = '0;
      end
      @(negedge clock);
      req = 3'b010;
      last = 3'b010;
      #1 chk_port("ns.resume", 3'b010, 3'b010, 1'b0);
      chk("ns.err", 32'(timeout_err), 0);
      @(negedge clock);
      req = '0;
      last = '0;
      #1 chk_port("ns.end", 3'b000, 3'b000, 1'b1);
      chk("ns.err2", 32'(timeout_err), 0);

      // single-pixel burst on requester 0
      reset_pulse();
      @(negedge clock);
      req = 3'b001;
      last = 3'b001;
      xv[0] = 8'd99;
      #1 chk_port("sp.req", 3'b000, 3'b000, 1'b0);
      @(negedge clock);
      #1 chk_port("sp.px", 3'b001, 3'b001, 1'b0);
      @(negedge clock);
      req = '0;
      last = '0;
      #1 chk_port("sp.end", 3'b000, 3'b000, 1'b1);
      chk("sp.x", 32'(out_x), 99);
      @(negedge clock);
      #1 chk_port("sp.idle", 3'b000, 3'b000, 1'b0);

      // reset mid-burst of requester 2, pointer returns to 0
      @(negedge clock);
      req = 3'b100;
      xv[2] = 8'd55;
      @(negedge clock);
      #1 chk_port("mr.px0", 3'b100, 3'b100, 1'b0);
      @(negedge clock);
      #1 chk_port("mr.px1", 3'b100, 3'b100, 1'b1);
      reset = 1'b0;
      #1 chk_zero("mr.rst");
      @(negedge clock);
      reset = 1'b1;
      req = 3'b101;
      @(negedge clock);
      #1 chk_port("mr.regrant", 3'b001, 3'b001, 1'b0);
      chk("mr.busy", 32'(busy), 1);
      req = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
